c432_tpg: RTL and testbench
===========================

# c432_tpg

Pseudo-random test-pattern generator that drives the 36 primary inputs of the c432 benchmark netlist in the fault-simulation harness. It produces a programmable number of 36-bit vectors from a 36-bit LFSR and presents each one through a valid/ready handshake to the downstream c432 evaluation and compaction stage. The block is the upstream stimulus stage for the c432 netlist. It is reseedable between runs so that software can partition one long sequence across parallel workers.

## Interface
- `WIDTH`, 36: pattern width; fixed to the c432 input count, and the LFSR polynomial is defined only for 36.
- `CNT_W`, 16: width of pattern count and index.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `seed_load` in 1: load `seed` into the LFSR; honoured only in IDLE.
- `seed` in 36: new LFSR state.
- `start` in 1: begin a run; honoured only in IDLE.
- `num_patterns` in CNT_W: patterns to emit; sampled on an accepted `start`.
- `pat_valid` out 1: `pat_data` holds a pattern.
- `pat_ready` in 1: consumer accepts the pattern this cycle.
- `pat_data` out 36: pattern; bit 0 drives `s1gat` through bit 35, which drives `s115gat`, in c432 input declaration order.
- `pat_idx` out CNT_W: zero-based index of the current pattern within the run.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at the end of a run.

## Operation
- **LFSR:** 36-bit Fibonacci LFSR, polynomial x^36 + x^25 + 1.
  - Each step: `fb = q[35] ^ q[24]`, then `q <= {q[34:0], fb}`.
  - Reset value is `36'h000000001`.
  - A zero `seed` loads `36'h000000001` instead, so the all-zero lockup state is never entered.
- **Seed and start in the same cycle:** if `seed_load` and `start` are both asserted in IDLE, the seed is loaded and the run starts, and the first pattern uses the new seed.
- **Sequence continuity:** the LFSR state persists across runs. Without a reload, a new run continues the previous sequence.
- **FSM states:**
  - **IDLE:** on `start` with `num_patterns != 0`, latch the count, clear `pat_idx`, go to RUN. On `start` with `num_patterns == 0`, go to DONE and emit no patterns.
  - **RUN:** `pat_valid = 1`.
    - On a handshake (`pat_valid & pat_ready`), step the LFSR and increment `pat_idx`.
    - If the handshake occurs at `pat_idx == count-1`, go to DONE instead. The LFSR still steps, so the next run resumes from the following state.
  - **DONE:** `done = 1` for exactly one cycle, then IDLE.
- **Ignored inputs:** `start` and `seed_load` in RUN or DONE are ignored. Changes to `num_patterns` after the count is latched are ignored.
- **Output hold:** `pat_data` and `pat_idx` stay stable while `pat_valid & !pat_ready`.
- **Reset mid-run:** `rst` in any state forces IDLE on the next edge with the LFSR at `36'h1`. Any pattern in flight is dropped and `done` is not pulsed.
- **Arithmetic:** `pat_idx` never wraps, because a run ends at `count-1` and `count` is at most 2^CNT_W−1.

## Timing
- **Reset values:** `pat_valid = 0`, `pat_data = 0`, `pat_idx = 0`, `busy = 0`, `done = 0`.
- `pat_data` is forced to 0 whenever `pat_valid = 0`.
- **Start latency:** `start` accepted at edge t gives `pat_valid = 1` and `busy = 1` after edge t, holding the pattern derived from the current LFSR state.
- **Throughput:** one pattern per cycle while `pat_ready` is held high.
- **End of run:** the final handshake at edge t gives `pat_valid = 0`, `busy = 0` and `done = 1` after edge t; `done = 0` after t+1.
- **Back-to-back runs:** the earliest next `start` is sampled in the cycle after `done`.
- All outputs are registered, with no combinational path from `pat_ready` to any output.

## Configuration
- **`C432_TPG_WEIGHT_EN` defined:** weighted mode. `pat_data = q & {q[34:0], q[35]}`, giving about 25% ones density to exercise the c432 low-activity request lines. The LFSR sequence itself is unchanged.
- **Not defined:** `pat_data = q`, uniform 50% density.

## Test plan
- **Reset, first patterns:** reset, then `start` with `num_patterns = 3` and `pat_ready = 1` → `pat_data` is `36'h000000001`, `36'h000000002`, `36'h000000004` with `pat_idx` 0, 1, 2; `done` pulses once, the cycle after the third handshake.
- **Feedback tap:** reset, run 26 patterns → pattern 24 is `36'h001000000` and pattern 25 is `36'h002000001`.
- **Backpressure:** `pat_ready` low for 5 cycles on pattern 1 → `pat_data` stays `36'h000000002` and `pat_idx` stays 1 throughout; no skipped or duplicated pattern.
- **Zero count and zero seed:**
  - `start` with `num_patterns = 0` → `done` one cycle later, `pat_valid` never asserted.
  - `seed_load` with `seed = 0` → next run's first pattern is `36'h000000001`.
- **Ignored inputs and resume:**
  - `start` or `seed_load` during RUN has no effect.
  - Reset asserted after 2 of 10 patterns → IDLE, no `done`, and the next run restarts at `36'h000000001`.
  - A run of 2 followed by a run of 2, with no reload, yields 1, 2 then 4, 8.
- **Weighted mode (`C432_TPG_WEIGHT_EN`):** seed `36'h000000003` → first pattern `36'h000000002`; seed `36'hFFFFFFFFF` → first pattern `36'hFFFFFFFFF`.

Source files
------------

// File: rtl/c432_tpg.sv
// Pseudo-random 36-bit pattern source for the c432 inputs: a Fibonacci LFSR (x^36 + x^25 + 1)
// behind a valid/ready handshake. Optional macro C432_TPG_WEIGHT_EN selects ~25% ones density.
module c432_tpg #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    output logic             pat_valid,
    input  logic             pat_ready,
    output logic [WIDTH-1:0] pat_data,
    output logic [CNT_W-1:0] pat_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_step, pat_d;
    logic [CNT_W-1:0] count_q, count_d, idx_q, idx_d;
    logic [WIDTH-1:0] pat_data_q;
    logic             pat_valid_q, busy_q, done_q;

    assign lfsr_step = {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1] ^ lfsr_q[24]};

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        count_d = count_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                // A zero seed would lock the LFSR, so it is replaced by 1.
                if (seed_load) begin
                    lfsr_d = (seed == '0) ? WIDTH'(1) : seed;
                end
                if (start) begin
                    count_d = num_patterns;
                    idx_d   = '0;
                    state_d = (num_patterns != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (pat_ready) begin
                    lfsr_d = lfsr_step;
                    if (idx_q == count_q - CNT_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifdef C432_TPG_WEIGHT_EN
    assign pat_d = lfsr_d & {lfsr_d[WIDTH-2:0], lfsr_d[WIDTH-1]};
`else
    assign pat_d = lfsr_d;
`endif

    // Outputs are registered from next-state values, so pat_ready never reaches a port
    // combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            lfsr_q      <= WIDTH'(1);
            count_q     <= '0;
            idx_q       <= '0;
            pat_data_q  <= '0;
            pat_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            pat_data_q  <= (state_d == StRun) ? pat_d : '0;
            pat_valid_q <= (state_d == StRun);
            busy_q      <= (state_d == StRun);
            done_q      <= (state_d == StDone);
        end
    end

    assign pat_valid = pat_valid_q;
    assign pat_data  = pat_data_q;
    assign pat_idx   = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_c432_tpg.sv
// Self-checking bench for c432_tpg: directed scenarios plus randomized runs checked against an
// arithmetic LFSR model. Define C432_TPG_WEIGHT_EN to check the weighted build.
module tb_c432_tpg;

    localparam longint unsigned Mask = (64'd1 << 36) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [35:0] seed = '0;
    logic        start = 1'b0;
    logic [15:0] num_patterns = '0;
    logic        pat_valid;
    logic        pat_ready = 1'b0;
    logic [35:0] pat_data;
    logic [15:0] pat_idx;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mdl = 64'd1;
    logic [63:0] seen[$];

    c432_tpg dut (
        .clk          (clk),
        .rst          (rst),
        .seed_load    (seed_load),
        .seed         (seed),
        .start        (start),
        .num_patterns (num_patterns),
        .pat_valid    (pat_valid),
        .pat_ready    (pat_ready),
        .pat_data     (pat_data),
        .pat_idx      (pat_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] step(input logic [63:0] q);
        logic [63:0] fb;
        fb = ((q >> 35) ^ (q >> 24)) & 64'd1;
        return ((q << 1) | fb) & Mask;
    endfunction

    function automatic logic [63:0] exp_pat(input logic [63:0] q);
`ifdef C432_TPG_WEIGHT_EN
        return q & (((q << 1) | (q >> 35)) & Mask);
`else
        return q;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pat_ready = 1'b0; start = 1'b0; seed_load = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        mdl = 64'd1;
    endtask

    // One run: start (optionally with a seed), then consume patterns with random or stalled
    // readiness while poking inputs that must be ignored.
    task automatic do_run(input int unsigned n, input int unsigned rdy_pct, input bit ld,
                          input logic [35:0] sd, input int unsigned stall_idx,
                          input int unsigned stall_n);
        int unsigned idx = 0;
        int unsigned stalls = 0;
        bit          rdy;
        logic [63:0] r;
        seen.delete();
        seed_load = ld; seed = sd; start = 1'b1; num_patterns = n[15:0];
        if (ld) mdl = (sd == '0) ? 64'd1 : {28'd0, sd};
        tick();
        start = 1'b0; seed_load = 1'b0; num_patterns = 16'($urandom);
        if (n == 0) begin
            chk("zero_valid", pat_valid, 0);
            chk("zero_done", done, 1);
            chk("zero_busy", busy, 0);
        end else begin
            while (idx < n) begin
                chk("run_valid", pat_valid, 1);
                chk("run_busy", busy, 1);
                chk("run_done", done, 0);
                chk("run_data", pat_data, exp_pat(mdl));
                chk("run_idx", pat_idx, idx);
                if (idx == stall_idx && stalls < stall_n) begin
                    rdy = 1'b0;
                    stalls++;
                end else begin
                    rdy = ($urandom_range(99) < rdy_pct);
                end
                pat_ready = rdy;
                r = {$urandom, $urandom};
                start = r[40]; seed_load = r[41]; seed = r[35:0];
                num_patterns = r[63:48];
                tick();
                if (rdy) begin
                    seen.push_back(exp_pat(mdl));
                    mdl = step(mdl);
                    idx++;
                end
            end
            chk("end_done", done, 1);
            chk("end_valid", pat_valid, 0);
            chk("end_busy", busy, 0);
            chk("end_data", pat_data, 0);
        end
        start = 1'b0; seed_load = 1'b0; pat_ready = 1'b0;
        tick();
        chk("done_pulse", done, 0);
        chk("idle_valid", pat_valid, 0);
    endtask

    initial begin
        logic [63:0] r;
        do_reset();
        chk("rst_valid", pat_valid, 0);
        chk("rst_data", pat_data, 0);
        chk("rst_idx", pat_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        do_run(3, 100, 0, '0, 99, 0);
`ifndef C432_TPG_WEIGHT_EN
        chk("first_p0", seen[0], 64'h1);
        chk("first_p1", seen[1], 64'h2);
        chk("first_p2", seen[2], 64'h4);
`endif

        do_reset();
        do_run(26, 100, 0, '0, 99, 0);
`ifndef C432_TPG_WEIGHT_EN
        chk("tap_p24", seen[24], 64'h001000000);
        chk("tap_p25", seen[25], 64'h002000001);
`endif

        do_reset();
        do_run(3, 100, 0, '0, 1, 5);
        chk("bp_count", seen.size(), 3);
`ifndef C432_TPG_WEIGHT_EN
        chk("bp_p1", seen[1], 64'h2);
        chk("bp_p2", seen[2], 64'h4);
`endif

        do_run(0, 100, 0, '0, 99, 0);
        do_run(2, 100, 1, '0, 99, 0);
`ifndef C432_TPG_WEIGHT_EN
        chk("zseed_p0", seen[0], 64'h1);
`endif

        do_reset();
        do_run(2, 100, 0, '0, 99, 0);
        do_run(2, 100, 0, '0, 99, 0);
`ifndef C432_TPG_WEIGHT_EN
        chk("resume_p0", seen[0], 64'h4);
        chk("resume_p1", seen[1], 64'h8);
`endif

        // Reset after two of ten handshakes: no done, sequence restarts.
        start = 1'b1; num_patterns = 16'd10;
        tick();
        start = 1'b0; pat_ready = 1'b1;
        tick();
        tick();
        chk("mid_idx", pat_idx, 2);
        rst = 1'b1; pat_ready = 1'b0;
        tick();
        chk("mid_valid", pat_valid, 0);
        chk("mid_done", done, 0);
        chk("mid_busy", busy, 0);
        rst = 1'b0;
        mdl = 64'd1;
        tick();
        chk("mid_done2", done, 0);
        do_run(1, 100, 0, '0, 99, 0);
`ifndef C432_TPG_WEIGHT_EN
        chk("mid_restart", seen[0], 64'h1);
`endif

`ifdef C432_TPG_WEIGHT_EN
        do_run(1, 100, 1, 36'h000000003, 99, 0);
        chk("wt_seed3", seen[0], 64'h000000002);
        do_run(1, 100, 1, 36'hFFFFFFFFF, 99, 0);
        chk("wt_ones", seen[0], 64'hFFFFFFFFF);
`endif

        for (int k = 0; k < 20; k++) begin
            r = {$urandom, $urandom};
            do_run($urandom_range(0, 40), $urandom_range(30, 100), r[60],
                   (r[63:61] == 3'd0) ? 36'd0 : r[35:0], $urandom_range(0, 5),
                   $urandom_range(0, 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
